// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Results are computed from latched operands and committed after a fixed per-class latency.
module mult_div_unit #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    typedef enum logic {StIdle, StRun} state_e;

    state_e            state_q;
    logic [CntW-1:0]   count_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [1:0]        op_q;

    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_u;
    logic               a_neg;
    logic               b_neg;
    logic               b_zero;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   b_safe;
    logic [WIDTH-1:0]   b_mag_safe;
    logic [WIDTH-1:0]   q_s;
    logic [WIDTH-1:0]   r_s;
    logic [WIDTH-1:0]   q_u;
    logic [WIDTH-1:0]   r_u;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    // Low 2*WIDTH bits of a product of sign-extended operands equal the signed product.
    assign prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
    assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

    assign a_neg      = a_q[WIDTH-1];
    assign b_neg      = b_q[WIDTH-1];
    assign b_zero     = (b_q == '0);
    assign a_mag      = a_neg ? -a_q : a_q;
    assign b_mag      = b_neg ? -b_q : b_q;
    assign b_safe     = b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b_q;
    assign b_mag_safe = b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;

    // Magnitude division: MIN / -1 wraps back to MIN with remainder 0 naturally.
    assign q_s = a_mag / b_mag_safe;
    assign r_s = a_mag % b_mag_safe;
    assign q_u = a_q / b_safe;
    assign r_u = a_q % b_safe;

    always_comb begin
        res_hi = '0;
        res_lo = '0;
        unique case (op_q)
            2'd0: {res_hi, res_lo} = prod_s;
            2'd1: {res_hi, res_lo} = prod_u;
            2'd2: begin
                if (b_zero) begin
                    res_lo = '1;
                    res_hi = a_q;
                end else begin
                    res_lo = (a_neg ^ b_neg) ? -q_s : q_s;
                    res_hi = a_neg ? -r_s : r_s;
                end
            end
            2'd3: begin
                if (b_zero) begin
                    res_lo = '1;
                    res_hi = a_q;
                end else begin
                    res_lo = q_u;
                    res_hi = r_u;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            count_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        if (!op[2]) begin
                            a_q     <= A;
                            b_q     <= B;
                            op_q    <= op[1:0];
                            count_q <= op[1] ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
                            busy    <= 1'b1;
                            state_q <= StRun;
                        end else if (op == 3'd4) begin
                            hi <= A;
                        end else if (op == 3'd5) begin
                            lo <= A;
                        end
                    end
                end
                StRun: begin
                    if (count_q == CntW'(1)) begin
                        hi      <= res_hi;
                        lo      <= res_lo;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        count_q <= '0;
                        state_q <= StIdle;
                    end else begin
                        count_q <= count_q - CntW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: default 32-bit instance with directed tables and corner sequences,
// plus an 8-bit / 1-cycle / 3-cycle instance driven with random operands against a model.
module tb_mult_div_unit;

    typedef struct packed {
        logic [31:0] h;
        logic [31:0] l;
    } res_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start1 = 1'b0;
    logic [2:0]  op1 = '0;
    logic [31:0] a1 = '0;
    logic [31:0] b1 = '0;
    logic        busy1;
    logic        done1;
    logic [31:0] hi1;
    logic [31:0] lo1;
    logic        start2 = 1'b0;
    logic [2:0]  op2 = '0;
    logic [7:0]  a2 = '0;
    logic [7:0]  b2 = '0;
    logic        busy2;
    logic        done2;
    logic [7:0]  hi2;
    logic [7:0]  lo2;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    res_t q1[$];
    res_t q2[$];
    res_t r1;
    res_t r2;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mult_div_unit dut32 (
        .clk(clk), .reset(reset), .start(start1), .op(op1), .A(a1), .B(b1),
        .busy(busy1), .done(done1), .hi(hi1), .lo(lo1)
    );

    mult_div_unit #(.WIDTH(8), .MULT_CYCLES(1), .DIV_CYCLES(3)) dut8 (
        .clk(clk), .reset(reset), .start(start2), .op(op2), .A(a2), .B(b2),
        .busy(busy2), .done(done2), .hi(hi2), .lo(lo2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void ref_model(input int w, input logic [2:0] op,
                                      input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] h, output logic [31:0] l);
        logic [63:0] mask, ua, ub, up;
        longint sa, sb, sp;
        mask = (64'd1 << w) - 64'd1;
        ua = {32'd0, a} & mask;
        ub = {32'd0, b} & mask;
        sa = (w == 32) ? longint'($signed(a)) : longint'($signed(a[7:0]));
        sb = (w == 32) ? longint'($signed(b)) : longint'($signed(b[7:0]));
        h = '0;
        l = '0;
        case (op)
            3'd0: begin
                sp = sa * sb;
                up = $unsigned(sp);
                h = 32'((up >> w) & mask);
                l = 32'(up & mask);
            end
            3'd1: begin
                up = ua * ub;
                h = 32'((up >> w) & mask);
                l = 32'(up & mask);
            end
            3'd2, 3'd3: begin
                if (ub == 64'd0) begin
                    l = 32'(mask);
                    h = 32'(ua);
                end else if (op == 3'd2) begin
                    l = 32'($unsigned(sa / sb) & mask);
                    h = 32'($unsigned(sa % sb) & mask);
                end else begin
                    l = 32'(ua / ub);
                    h = 32'(ua % ub);
                end
            end
            default: ;
        endcase
    endfunction

    // Scoreboards: every done pulse must match the oldest outstanding expectation.
    always @(posedge clk) begin
        #1;
        if (reset && done1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done32_unexpected: got done=1 hi=%h lo=%h expected no done", hi1, lo1);
            end else begin
                r1 = q1.pop_front();
                check("sb32_hi", 64'(hi1), 64'(r1.h));
                check("sb32_lo", 64'(lo1), 64'(r1.l));
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (reset && done2) begin
            if (q2.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done8_unexpected: got done=1 hi=%h lo=%h expected no done", hi2, lo2);
            end else begin
                r2 = q2.pop_front();
                check("sb8_hi", 64'(hi2), 64'(r2.h[7:0]));
                check("sb8_lo", 64'(lo2), 64'(r2.l[7:0]));
            end
        end
    end

    // Issue one mult/div on the 32-bit unit from idle and check its handshake timing.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el);
        int n;
        int bc;
        n = (op < 3'd2) ? 5 : 10;
        start1 = 1'b1;
        op1 = op;
        a1 = a;
        b1 = b;
        q1.push_back('{h: eh, l: el});
        tick();
        start1 = 1'b0;
        a1 = ~a;
        b1 = ~b;
        check("hold_hi", 64'(hi1), 64'(m_hi));
        check("hold_lo", 64'(lo1), 64'(m_lo));
        bc = 0;
        while (busy1 && bc < 50) begin
            bc++;
            tick();
        end
        check("busy_len32", 64'(bc), 64'(n));
        check("done32", 64'(done1), 64'd1);
        m_hi = eh;
        m_lo = el;
    endtask

    vec_t vecs[9];

    initial begin
        int bc;
        int last;
        int prev_n;
        int n;
        logic [2:0]  rop;
        logic [31:0] ra, rb, rh, rl;

        vecs[0] = '{3'd0, 32'hFFFFFFFF, 32'd2,         32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[1] = '{3'd1, 32'hFFFFFFFF, 32'd2,         32'h00000001, 32'hFFFFFFFE};
        vecs[2] = '{3'd2, 32'hFFFFFFF9, 32'd2,         32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{3'd3, 32'd7,        32'd0,         32'd7,        32'hFFFFFFFF};
        vecs[4] = '{3'd2, 32'h80000000, 32'hFFFFFFFF,  32'd0,        32'h80000000};
        vecs[5] = '{3'd2, 32'd7,        32'hFFFFFFFE,  32'd1,        32'hFFFFFFFD};
        vecs[6] = '{3'd1, 32'h00010000, 32'h00010000,  32'd1,        32'd0};
        vecs[7] = '{3'd3, 32'd100,      32'd7,         32'd2,        32'd14};
        vecs[8] = '{3'd2, 32'd0,        32'd0,         32'd0,        32'hFFFFFFFF};

        tick();
        tick();
        check("rst_busy32", 64'(busy1), 64'd0);
        check("rst_done32", 64'(done1), 64'd0);
        check("rst_hi32", 64'(hi1), 64'd0);
        check("rst_lo32", 64'(lo1), 64'd0);
        check("rst_busy8", 64'(busy2), 64'd0);
        check("rst_hi8", 64'(hi2), 64'd0);
        reset = 1'b1;
        tick();

        // MTHI then MTLO on consecutive cycles.
        start1 = 1'b1;
        op1 = 3'd4;
        a1 = 32'hDEADBEEF;
        tick();
        check("mthi_hi", 64'(hi1), 64'hDEADBEEF);
        check("mthi_busy", 64'(busy1), 64'd0);
        op1 = 3'd5;
        a1 = 32'h0BADF00D;
        tick();
        start1 = 1'b0;
        check("mtlo_lo", 64'(lo1), 64'h0BADF00D);
        check("mtlo_hi", 64'(hi1), 64'hDEADBEEF);
        check("mtlo_busy", 64'(busy1), 64'd0);
        check("mtlo_done", 64'(done1), 64'd0);
        m_hi = 32'hDEADBEEF;
        m_lo = 32'h0BADF00D;

        // Reserved op leaves everything untouched.
        start1 = 1'b1;
        op1 = 3'd6;
        a1 = 32'h55555555;
        tick();
        start1 = 1'b0;
        check("rsvd_hi", 64'(hi1), 64'hDEADBEEF);
        check("rsvd_busy", 64'(busy1), 64'd0);

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo);
        end
        tick();

        // Busy rejection: MTHI and MULT issued mid-DIV are dropped.
        start1 = 1'b1;
        op1 = 3'd2;
        a1 = 32'd100;
        b1 = 32'd7;
        q1.push_back('{h: 32'd2, l: 32'd14});
        tick();
        start1 = 1'b0;
        tick();
        tick();
        start1 = 1'b1;
        op1 = 3'd4;
        a1 = 32'h1234;
        tick();
        start1 = 1'b0;
        tick();
        start1 = 1'b1;
        op1 = 3'd0;
        a1 = 32'd3;
        b1 = 32'd3;
        tick();
        start1 = 1'b0;
        check("rej_hold_hi", 64'(hi1), 64'(m_hi));
        bc = 0;
        while (busy1 && bc < 50) begin
            bc++;
            tick();
        end
        check("rej_busy_tail", 64'(bc), 64'd5);
        check("rej_done", 64'(done1), 64'd1);
        check("rej_hi", 64'(hi1), 64'd2);
        for (int i = 0; i < 8; i++) tick();
        check("rej_no_mult", 64'(busy1), 64'd0);
        m_hi = 32'd2;
        m_lo = 32'd14;

        // Reset in the middle of a DIV discards it.
        start1 = 1'b1;
        op1 = 3'd3;
        a1 = 32'd50;
        b1 = 32'd3;
        tick();
        start1 = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("midrst_busy", 64'(busy1), 64'd0);
        check("midrst_done", 64'(done1), 64'd0);
        check("midrst_hi", 64'(hi1), 64'd0);
        check("midrst_lo", 64'(lo1), 64'd0);
        m_hi = '0;
        m_lo = '0;
        for (int i = 0; i < 12; i++) tick();
        run_op(3'd0, 32'd3, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFF1);
        tick();

        // Narrow instance: random back-to-back ops against the model.
        last = 0;
        prev_n = 0;
        for (int i = 0; i < 24; i++) begin
            rop = 3'($urandom_range(0, 3));
            ra = 32'($urandom_range(0, 255));
            rb = 32'($urandom_range(0, 255));
            if (i % 7 == 3) rb = 32'd0;
            if (i == 5) begin
                rop = 3'd2;
                ra = 32'h80;
                rb = 32'hFF;
            end
            ref_model(8, rop, ra, rb, rh, rl);
            n = (rop < 3'd2) ? 1 : 3;
            start2 = 1'b1;
            op2 = rop;
            a2 = ra[7:0];
            b2 = rb[7:0];
            q2.push_back('{h: rh, l: rl});
            tick();
            start2 = 1'b0;
            if (i > 0) check("period8", 64'(cyc - last), 64'(prev_n + 1));
            last = cyc;
            prev_n = n;
            bc = 0;
            while (busy2 && bc < 20) begin
                bc++;
                tick();
            end
            check("busy_len8", 64'(bc), 64'(n));
            check("done8", 64'(done2), 64'd1);
        end

        tick();
        tick();
        check("sb32_drained", 64'(q1.size()), 64'd0);
        check("sb8_drained", 64'(q2.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
